// File: rtl/tc2sm_serial.sv
// Digit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
// Optional build macro TC2SM_FASTPATH_EN: non-negative operands skip the serial negation.
module tc2sm_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_o,
  output logic [WIDTH-1:0] mag_o,
  output logic             is_min_o
);

  localparam int NCYC = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0]    LAST = CW'(NCYC - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             prop_q;
  logic             sign_q;
  logic             is_min_q;
  logic [WIDTH-1:0] mag_q;

  logic [WIDTH-1:0] mag_nxt;
  logic             prop_nxt;
  logic             p;
  logic             ai;

  // Negate the current digit in place: invert and propagate the +1 through a prefix-AND chain.
  // Bits outside digit cnt_q are left alone, so a partial top digit simply has fewer bits.
  always_comb begin
    mag_nxt = mag_q;
    p       = prop_q;
    ai      = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sign_q && (cnt_q == CW'(b / DIGIT))) begin
        ai         = ~mag_q[b];
        mag_nxt[b] = ai ^ p;
        p          = ai & p;
      end
    end
    prop_nxt = p;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      is_min_q  <= 1'b0;
      cnt_q     <= '0;
      prop_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag_q    <= a_i;
            sign_q   <= a_i[WIDTH-1];
            is_min_q <= 1'b0;
            cnt_q    <= '0;
            prop_q   <= 1'b1;
            in_ready <= 1'b0;
`ifdef TC2SM_FASTPATH_EN
            if (!a_i[WIDTH-1]) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          mag_q  <= mag_nxt;
          prop_q <= prop_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            is_min_q  <= sign_q && (mag_nxt == MINV);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign sign_o   = sign_q;
  assign mag_o    = mag_q;
  assign is_min_o = is_min_q;

endmodule

// File: tb/tb_tc2sm_serial.sv
// Scoreboard bench for tc2sm_serial across several WIDTH/DIGIT configurations run in parallel.
module tb_tc2sm_serial;

  localparam int NCFG  = 4;
  localparam int NRAND = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 7 : (g == 2) ? 5 : 10;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;
    localparam int NC = (W + D - 1) / D;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic         sign;
    logic [W-1:0] mag;
    logic         is_min;

    tc2sm_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_i      (a),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sign_o   (sign),
      .mag_o    (mag),
      .is_min_o (is_min)
    );

    typedef struct {
      logic [W-1:0] mag;
      logic         sign;
      logic         is_min;
      int           acc;
      int           lat;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   hold_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: magnitude is 2^W - a for negative a, a otherwise.
    function automatic exp_t model(input logic [W-1:0] v, input int acc);
      exp_t e;
      longint unsigned u;
      longint unsigned m;
      u = 64'(v);
      m = v[W-1] ? ((64'd1 << W) - u) : u;
      e.mag    = W'(m);
      e.sign   = v[W-1];
      e.is_min = v[W-1] && (u == (64'd1 << (W - 1)));
      e.acc    = acc;
      e.lat    = NC + 1;
`ifdef TC2SM_FASTPATH_EN
      if (!v[W-1]) e.lat = 1;
`endif
      return e;
    endfunction

    task automatic send(input logic [W-1:0] v, input bit push);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      a = v;
      for (int i = 0; i < 400; i++) begin
        if (in_ready) begin
          ok = 1'b1;
          @(posedge clk);
          #1;
          break;
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      if (ok) begin
        a = W'($urandom);
        if (push) q.push_back(model(v, cyc));
      end else begin
        check("accept_timeout", 64'(in_ready), 64'd1);
      end
    endtask

    task automatic drain();
      for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
      check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_sign"},      64'(sign),      64'd0);
      check({tag, "_mag"},       64'(mag),       64'd0);
      check({tag, "_is_min"},    64'(is_min),    64'd0);
    endtask

    initial begin : driver
      logic [W-1:0] dir[7];
      logic [W-1:0] bp;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      dir[0] = W'(-5);
      dir[1] = {1'b1, {(W-1){1'b0}}};
      dir[2] = '0;
      dir[3] = '1;
      dir[4] = {1'b0, {(W-1){1'b1}}};
      dir[5] = dir[1] + W'(1);
      dir[6] = W'(1);
      for (int i = 0; i < 7; i++) send(dir[i], 1'b1);

      drain();
      bp = '0;
      bp[W-1:W-2] = 2'b11;
      hold_n = 3;
      send(bp, 1'b1);

      drain();
      send(W'(-3), 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midbusy_reset");
      @(negedge clk);
      rst_n = 1'b1;
      send('1, 1'b1);

      for (int n = 0; n < NRAND; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(W'($urandom), 1'b1);
      end
      drain();
      n_done++;
    end

    initial begin : monitor
      exp_t e;
      bit prev_ov;
      bit prev_hs;
      prev_ov   = 1'b0;
      prev_hs   = 1'b0;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_ov = 1'b0;
          prev_hs = 1'b0;
        end else begin
          if (prev_hs) begin
            check("in_ready_after_hs",   64'(in_ready),  64'd1);
            check("out_valid_after_hs",  64'(out_valid), 64'd0);
          end
          prev_hs = 1'b0;
          if (out_valid) begin
            check("in_ready_while_valid", 64'(in_ready), 64'd0);
            if (q.size() == 0) begin
              check("unexpected_out", 64'(out_valid), 64'd0);
              out_ready = 1'b1;
            end else begin
              e = q[0];
              if (!prev_ov) check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
              check("sign",   64'(sign),   64'(e.sign));
              check("mag",    64'(mag),    64'(e.mag));
              check("is_min", 64'(is_min), 64'(e.is_min));
              if (hold_n > 0) begin
                out_ready = 1'b0;
                hold_n--;
              end else begin
                out_ready = ($urandom_range(0, 3) != 0);
              end
              if (out_ready) begin
                void'(q.pop_front());
                prev_hs = 1'b1;
              end
            end
          end else begin
            out_ready = 1'(($urandom_range(0, 1)));
          end
          prev_ov = out_valid;
        end
      end
    end
  end

  initial begin : top
    for (int t = 0; t < 95000 && n_done < NCFG; t++) @(posedge clk);
    check("run_timeout", 64'(n_done), 64'(NCFG));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
